sram_port_ctrl: RTL and testbench
=================================

// Module: sram_port_ctrl
// PURPOSE
//  Initiator for one masked single-port SRAM macro (RW0_* port: addr/en/wmode/wmask/wdata, 1-cycle rdata).
//  Takes valid/ready read/write requests, drives the macro port, and captures read data the cycle after issue.
//  Returns read data in order through a valid/ready response FIFO.
//  Optionally zero-fills the whole array after reset, so simulation and FPGA start from known contents.
// PARAMETERS
//  ADDR_W      9    address width; array depth = 2**ADDR_W
//  DATA_W      256  data width
//  GRAN        8    bits per write-mask lane; DATA_W % GRAN == 0
//  MASK_W      DATA_W/GRAN (derived, localparam)
//  RESP_DEPTH  3    response FIFO entries; >=1; 3 needed for full read throughput
//  INIT_EN     1    1: zero-fill the array after reset; 0: go straight to RUN
// PORTS
//  clock        in   1       clock; the macro's RW0_clk is tied to this clock
//  reset        in   1       synchronous, active-high
//  req_valid    in   1       request valid
//  req_ready    out  1       request accepted when req_valid && req_ready (fire)
//  req_write    in   1       1 = masked write, 0 = read
//  req_addr     in   ADDR_W  word address
//  req_wdata    in   DATA_W  write data
//  req_wmask    in   MASK_W  lane i writes bits [i*GRAN +: GRAN]
//  resp_valid   out  1       read data valid
//  resp_ready   in   1       response consumed when resp_valid && resp_ready (pop)
//  resp_rdata   out  DATA_W  read data, in request order
//  init_busy    out  1       high while zero-fill runs
//  sram_en      out  1       -> RW0_en
//  sram_wmode   out  1       -> RW0_wmode
//  sram_addr    out  ADDR_W  -> RW0_addr
//  sram_wmask   out  MASK_W  -> RW0_wmask
//  sram_wdata   out  DATA_W  -> RW0_wdata
//  sram_rdata   in   DATA_W  <- RW0_rdata; valid only in the cycle after a read issue
// BEHAVIOUR
//  States: INIT, RUN. Reset -> INIT if INIT_EN, else RUN.
//  Values while reset is high and in the cycle after:
//   req_ready=0, resp_valid=0, sram_en=0, init_busy=INIT_EN, FIFO empty, inflight=0, init_cnt=0.
//  INIT:
//   - Each cycle: sram_en=1, wmode=1, wmask=all-ones, wdata=0, addr=init_cnt; then init_cnt++.
//   - After addr 2**ADDR_W-1 is written: RUN next cycle, init_busy=0. Takes exactly 2**ADDR_W cycles.
//   - req_ready=0 throughout.
//  RUN:
//   - req_ready = (fifo_count + inflight < RESP_DEPTH).
//   - req_ready depends only on registered state: no path from req_valid, req_write or resp_ready.
//   - Writes are subject to the same ready rule.
//   - sram_* driven combinationally from req_* when fire: en=1, wmode=req_write.
//   - On a read, wmask and wdata are don't-care; the implementation drives them to 0.
//   - No fire: sram_en=0.
//   - Read fire in cycle N: inflight=1 in N+1. sram_rdata is pushed into the FIFO at the end of N+1.
//   - resp_valid first asserts in N+2 (latency 2). inflight clears unless another read fired in N+1.
//   - Writes produce no response. Write fire in N is visible to a read fired in N+1 or later.
//  FIFO:
//   - Circular, RESP_DEPTH entries; registered resp_rdata = head.
//   - Push and pop in the same cycle keeps the count unchanged.
//   - Cannot overflow: the credit rule reserves a slot at issue.
//   - Pointers wrap modulo RESP_DEPTH; RESP_DEPTH need not be a power of 2.
//  Throughput:
//   - RESP_DEPTH>=3 with resp_ready held 1: one read per cycle sustained.
//   - RESP_DEPTH=2 with resp_ready held 1: 2 reads per 3 cycles.
//  Reset mid-operation: inflight read dropped, FIFO flushed, INIT restarts from addr 0.
//  Counter widths: fifo_count is $clog2(RESP_DEPTH+1) bits; init_cnt is ADDR_W+1 bits (terminal detect).
// STRUCTURE
//  - sram_ctrl_pkg: state enum {INIT, RUN} and the clog2 helper.
//  - Sub-module sram_resp_fifo (DATA_W, RESP_DEPTH): push/pop/count/head.
//  - Top holds the FSM, init counter, inflight flag, credit check and sram_* muxing.
// TESTING
//  1 Reset 2 cycles, INIT_EN=1, ADDR_W=9 ->
//    512 cycles of en=1, wmode=1, mask=all-ones, wdata=0, addr 0..511;
//    init_busy falls after cycle 512; then read addr 5 -> resp_rdata=0.
//  2 Write addr 0x1A3, data={32{8'hA5}}, mask=32'h0000000F; then read 0x1A3 ->
//    bits[31:0]=32'hA5A5A5A5, remaining bits 0.
//  3 16 back-to-back reads, addrs 0..15 pre-written with value=addr, resp_ready=1 ->
//    req_ready stays 1; responses 0..15 in order; each exactly 2 cycles after fire.
//  4 resp_ready=0, req_valid held with reads ->
//    exactly 3 fires, then req_ready=0; resp_ready=1 drains 3 responses in order, then issuing resumes.
//  5 Write addr 7=X in cycle N, read addr 7 in cycle N+1 -> X returned.
//  6 reset asserted with FIFO holding 2 entries and 1 read inflight ->
//    next cycle resp_valid=0; INIT restarts at addr 0; no stale response ever appears.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the single-port SRAM initiator.
// State encoding and a constant-foldable ceil(log2) used to size counters and pointers.
package sram_ctrl_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } sram_state_e;

    function automatic int calc_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sram_resp_fifo.sv
// Circular read-response FIFO; depth need not be a power of two.
// Head is a register read, so consumers see stable data with no comb path from the SRAM.
module sram_resp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 3,
    localparam int CNT_W = calc_clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? calc_clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_head,
    output logic [CNT_W-1:0]  o_count
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_pop = i_pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Data storage needs no reset; occupancy is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_valid = (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/sram_port_ctrl.sv
// Initiator for one masked single-port SRAM macro with optional post-reset zero-fill.
// Handshakes: a transfer happens on a cycle where valid && ready; ready never depends on valid.
module sram_port_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 256,
    parameter int GRAN       = 8,
    parameter int RESP_DEPTH = 3,
    parameter int INIT_EN    = 1,
    localparam int MASK_W    = DATA_W / GRAN
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [MASK_W-1:0] req_wmask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              init_busy,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output sram_state_e       dbg_state
);

    localparam int CNT_W = calc_clog2(RESP_DEPTH + 1);
    localparam logic [ADDR_W:0] INIT_LAST = {1'b0, {ADDR_W{1'b1}}};
    localparam sram_state_e RESET_STATE = (INIT_EN != 0) ? ST_INIT : ST_RUN;

    sram_state_e       r_state;
    sram_state_e       w_state_next;
    logic [ADDR_W:0]   r_init_cnt;
    logic              r_inflight;
    logic              r_hold;
    logic              w_quiet;
    logic              w_init_wr;
    logic              w_fire;
    logic              w_fifo_valid;
    logic              w_pop;
    logic [CNT_W-1:0]  w_fifo_count;
    logic [CNT_W:0]    w_credit_used;
    logic              w_has_credit;

    // r_hold keeps the port idle for the first cycle after reset is released.
    assign w_quiet = reset || r_hold;

    assign w_credit_used = {1'b0, w_fifo_count} + {{CNT_W{1'b0}}, r_inflight};
    assign w_has_credit  = (w_credit_used < (CNT_W + 1)'(RESP_DEPTH));
    assign w_fire        = req_valid && req_ready;

    always_ff @(posedge clock) begin
        if (reset) r_state <= RESET_STATE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (r_state == ST_INIT && !w_quiet && r_init_cnt == INIT_LAST) w_state_next = ST_RUN;
    end

    always_comb begin
        w_init_wr  = 1'b0;
        req_ready  = 1'b0;
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = '0;
        sram_wmask = '0;
        sram_wdata = '0;
        if (!w_quiet) begin
            case (r_state)
                ST_INIT: begin
                    w_init_wr  = 1'b1;
                    sram_en    = 1'b1;
                    sram_wmode = 1'b1;
                    sram_addr  = r_init_cnt[ADDR_W-1:0];
                    sram_wmask = '1;
                end
                ST_RUN: begin
                    req_ready = w_has_credit;
                    if (req_valid && w_has_credit) begin
                        sram_en    = 1'b1;
                        sram_wmode = req_write;
                        sram_addr  = req_addr;
                        if (req_write) begin
                            sram_wmask = req_wmask;
                            sram_wdata = req_wdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hold     <= 1'b1;
            r_init_cnt <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_hold     <= 1'b0;
            if (w_init_wr) r_init_cnt <= r_init_cnt + (ADDR_W + 1)'(1);
            r_inflight <= w_fire && !req_write;
        end
    end

    // A read issued last cycle has its data on sram_rdata now; the credit check guarantees room.
    sram_resp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RESP_DEPTH)
    ) u_resp_fifo (
        .clk         (clock),
        .rst         (reset),
        .i_push      (r_inflight),
        .i_push_data (sram_rdata),
        .i_pop       (w_pop),
        .o_valid     (w_fifo_valid),
        .o_head      (resp_rdata),
        .o_count     (w_fifo_count)
    );

    assign resp_valid = w_fifo_valid && !reset;
    assign w_pop      = resp_valid && resp_ready;
    assign init_busy  = reset ? (INIT_EN != 0) : (r_state == ST_INIT);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Directed bench for sram_port_ctrl with a behavioural masked SRAM macro attached.
module tb_sram_port_ctrl;
    import sram_ctrl_pkg::*;

    localparam int ADDR_W     = 9;
    localparam int DATA_W     = 256;
    localparam int GRAN       = 8;
    localparam int MASK_W     = DATA_W / GRAN;
    localparam int RESP_DEPTH = 3;
    localparam int DEPTH      = 1 << ADDR_W;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic [MASK_W-1:0] req_wmask = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b1;
    logic [DATA_W-1:0] resp_rdata;
    logic              init_busy;
    logic              sram_en;
    logic              sram_wmode;
    logic [ADDR_W-1:0] sram_addr;
    logic [MASK_W-1:0] sram_wmask;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata = '0;
    sram_state_e       dbg_state;

    int n_total = 0;
    int n_bad   = 0;

    sram_port_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .GRAN(GRAN), .RESP_DEPTH(RESP_DEPTH), .INIT_EN(1)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .init_busy(init_busy),
        .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
        .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- SRAM macro model ----------------
    logic [DATA_W-1:0] mem [DEPTH];

    initial begin
        for (int a = 0; a < DEPTH; a++) mem[a] <= ~DATA_W'(a);
    end

    always @(posedge clock) begin
        if (sram_en && sram_wmode) begin
            for (int l = 0; l < MASK_W; l++) begin
                if (sram_wmask[l]) mem[sram_addr][l*GRAN +: GRAN] <= sram_wdata[l*GRAN +: GRAN];
            end
        end
        if (sram_en && !sram_wmode) sram_rdata <= mem[sram_addr];
        else                        sram_rdata <= {8{32'hBAD0_BAD0}};
    end

    // ---------------- driver tasks ----------------
    task automatic advance();
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                            input logic [MASK_W-1:0] mask);
        int n;
        req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_wdata = data; req_wmask = mask;
        n = 0;
        @(negedge clock);
        while (!req_ready && n < 20) begin
            advance(); @(negedge clock); n++;
        end
        n_total++;
        if (!req_ready) begin
            n_bad++;
            $display("FAIL write_accept: addr %0d req_ready %b want 1 within 20 cycles", addr, req_ready);
        end
        advance();
        req_valid = 1'b0; req_write = 1'b0;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] addr, output logic [DATA_W-1:0] data);
        int n;
        req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_wdata = '0; req_wmask = '0;
        resp_ready = 1'b1;
        n = 0;
        @(negedge clock);
        while (!req_ready && n < 20) begin
            advance(); @(negedge clock); n++;
        end
        n_total++;
        if (!req_ready) begin
            n_bad++;
            $display("FAIL read_accept: addr %0d req_ready %b want 1 within 20 cycles", addr, req_ready);
        end
        advance();
        req_valid = 1'b0;
        n = 0;
        @(negedge clock);
        while (!resp_valid && n < 20) begin
            advance(); @(negedge clock); n++;
        end
        n_total++;
        if (!resp_valid) begin
            n_bad++;
            $display("FAIL read_resp: addr %0d resp_valid %b want 1 within 20 cycles", addr, resp_valid);
        end
        data = resp_rdata;
        advance();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
        repeat (2) begin
            @(negedge clock);
            n_total++; if (req_ready !== 1'b0)  begin n_bad++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
            n_total++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
            n_total++; if (sram_en !== 1'b0)    begin n_bad++; $display("FAIL rst_sram_en: got %b want 0", sram_en); end
            n_total++; if (init_busy !== 1'b1)  begin n_bad++; $display("FAIL rst_init_busy: got %b want 1", init_busy); end
            advance();
        end
        reset = 1'b0;
        @(negedge clock);
        n_total++; if (req_ready !== 1'b0)  begin n_bad++; $display("FAIL post_rst_req_ready: got %b want 0", req_ready); end
        n_total++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL post_rst_resp_valid: got %b want 0", resp_valid); end
        n_total++; if (sram_en !== 1'b0)    begin n_bad++; $display("FAIL post_rst_sram_en: got %b want 0", sram_en); end
        n_total++; if (init_busy !== 1'b1)  begin n_bad++; $display("FAIL post_rst_init_busy: got %b want 1", init_busy); end
        n_total++; if (dbg_state !== ST_INIT) begin n_bad++; $display("FAIL post_rst_state: got %0d want INIT", dbg_state); end
    endtask

    task automatic test_init();
        logic [DATA_W-1:0] data;
        for (int i = 0; i < DEPTH; i++) begin
            advance();
            @(negedge clock);
            n_total++; if (sram_en !== 1'b1)    begin n_bad++; $display("FAIL init_en[%0d]: got %b want 1", i, sram_en); end
            n_total++; if (sram_wmode !== 1'b1) begin n_bad++; $display("FAIL init_wmode[%0d]: got %b want 1", i, sram_wmode); end
            n_total++; if (sram_addr !== ADDR_W'(i)) begin n_bad++; $display("FAIL init_addr[%0d]: got %0d want %0d", i, sram_addr, i); end
            n_total++; if (sram_wmask !== {MASK_W{1'b1}}) begin n_bad++; $display("FAIL init_mask[%0d]: got %h want all ones", i, sram_wmask); end
            n_total++; if (sram_wdata !== {DATA_W{1'b0}}) begin n_bad++; $display("FAIL init_wdata[%0d]: got %h want 0", i, sram_wdata); end
            n_total++; if (init_busy !== 1'b1)  begin n_bad++; $display("FAIL init_busy[%0d]: got %b want 1", i, init_busy); end
            n_total++; if (req_ready !== 1'b0)  begin n_bad++; $display("FAIL init_req_ready[%0d]: got %b want 0", i, req_ready); end
        end
        advance();
        @(negedge clock);
        n_total++; if (init_busy !== 1'b0)  begin n_bad++; $display("FAIL init_done_busy: got %b want 0", init_busy); end
        n_total++; if (dbg_state !== ST_RUN) begin n_bad++; $display("FAIL init_done_state: got %0d want RUN", dbg_state); end
        n_total++; if (req_ready !== 1'b1)  begin n_bad++; $display("FAIL init_done_ready: got %b want 1", req_ready); end
        n_total++; if (sram_en !== 1'b0)    begin n_bad++; $display("FAIL init_done_en: got %b want 0", sram_en); end
        advance();
        do_read(ADDR_W'(5), data);
        n_total++; if (data !== {DATA_W{1'b0}}) begin n_bad++; $display("FAIL init_read5: got %h want 0", data); end
    endtask

    task automatic test_masked_write();
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp;
        logic [DATA_W-1:0] data;
        wdata = {32{8'hA5}};
        exp   = {{(DATA_W-32){1'b0}}, 32'hA5A5A5A5};
        req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h1A3; req_wdata = wdata; req_wmask = 32'h0000000F;
        @(negedge clock);
        n_total++; if (req_ready !== 1'b1)  begin n_bad++; $display("FAIL mw_ready: got %b want 1", req_ready); end
        n_total++; if (sram_en !== 1'b1)    begin n_bad++; $display("FAIL mw_en: got %b want 1", sram_en); end
        n_total++; if (sram_wmode !== 1'b1) begin n_bad++; $display("FAIL mw_wmode: got %b want 1", sram_wmode); end
        n_total++; if (sram_addr !== 9'h1A3) begin n_bad++; $display("FAIL mw_addr: got %h want 1a3", sram_addr); end
        n_total++; if (sram_wmask !== 32'h0000000F) begin n_bad++; $display("FAIL mw_mask: got %h want 0000000f", sram_wmask); end
        n_total++; if (sram_wdata !== wdata) begin n_bad++; $display("FAIL mw_wdata: got %h want %h", sram_wdata, wdata); end
        advance();
        req_write = 1'b0; req_wdata = wdata; req_wmask = '1;
        @(negedge clock);
        n_total++; if (sram_wmode !== 1'b0) begin n_bad++; $display("FAIL rd_wmode: got %b want 0", sram_wmode); end
        n_total++; if (sram_wmask !== {MASK_W{1'b0}}) begin n_bad++; $display("FAIL rd_mask: got %h want 0", sram_wmask); end
        n_total++; if (sram_wdata !== {DATA_W{1'b0}}) begin n_bad++; $display("FAIL rd_wdata: got %h want 0", sram_wdata); end
        advance();
        req_valid = 1'b0;
        advance();
        do_read(9'h1A3, data);
        n_total++; if (data !== exp) begin n_bad++; $display("FAIL mw_readback: got %h want %h", data, exp); end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] exp_q[$];
        logic [DATA_W-1:0] exp;
        int fire_cyc [16];
        int k;
        int got;
        int cyc;
        for (int a = 0; a < 16; a++) do_write(ADDR_W'(a), DATA_W'(a), '1);
        resp_ready = 1'b1;
        k = 0; got = 0; cyc = 0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = '0;
        while (got < 16 && cyc < 60) begin
            @(negedge clock);
            if (k < 16) begin
                n_total++;
                if (req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready[%0d]: got %b want 1", k, req_ready); end
                if (req_ready === 1'b1) begin
                    fire_cyc[k] = cyc;
                    exp_q.push_back(DATA_W'(k));
                    k++;
                end
            end
            if (resp_valid === 1'b1) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : {DATA_W{1'b1}};
                n_total++;
                if (resp_rdata !== exp) begin n_bad++; $display("FAIL b2b_data[%0d]: got %h want %h", got, resp_rdata, exp); end
                n_total++;
                if (cyc - fire_cyc[got] != 2) begin n_bad++; $display("FAIL b2b_latency[%0d]: got %0d want 2", got, cyc - fire_cyc[got]); end
                got++;
            end
            advance();
            cyc++;
            if (k < 16) req_addr = ADDR_W'(k);
            else        req_valid = 1'b0;
        end
        req_valid = 1'b0;
        n_total++; if (got != 16) begin n_bad++; $display("FAIL b2b_count: got %0d want 16", got); end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] exp_q[$];
        logic [DATA_W-1:0] exp;
        logic [DATA_W-1:0] data;
        int fires;
        int got;
        int n;
        resp_ready = 1'b0;
        fires = 0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (req_ready === 1'b1) begin
                exp_q.push_back(DATA_W'(fires));
                fires++;
            end
            advance();
            req_addr = ADDR_W'(fires);
        end
        @(negedge clock);
        n_total++; if (fires != 3) begin n_bad++; $display("FAIL bp_fires: got %0d want 3", fires); end
        n_total++; if (req_ready !== 1'b0)  begin n_bad++; $display("FAIL bp_ready: got %b want 0", req_ready); end
        n_total++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_resp_valid: got %b want 1", resp_valid); end
        advance();
        req_valid = 1'b0;
        resp_ready = 1'b1;
        got = 0; n = 0;
        while (got < 3 && n < 12) begin
            @(negedge clock);
            if (resp_valid === 1'b1) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : {DATA_W{1'b1}};
                n_total++;
                if (resp_rdata !== exp) begin n_bad++; $display("FAIL bp_drain[%0d]: got %h want %h", got, resp_rdata, exp); end
                got++;
            end
            advance();
            n++;
        end
        n_total++; if (got != 3) begin n_bad++; $display("FAIL bp_drain_count: got %0d want 3", got); end
        @(negedge clock);
        n_total++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty: got %b want 0", resp_valid); end
        advance();
        do_read(ADDR_W'(3), data);
        n_total++; if (data !== DATA_W'(3)) begin n_bad++; $display("FAIL bp_resume: got %h want 3", data); end
    endtask

    task automatic test_write_then_read();
        logic [DATA_W-1:0] x;
        int n;
        x = {8{32'hDEADBEEF}};
        req_valid = 1'b1; req_write = 1'b1; req_addr = ADDR_W'(7); req_wdata = x; req_wmask = '1;
        @(negedge clock);
        n_total++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL raw_wr_ready: got %b want 1", req_ready); end
        advance();
        req_write = 1'b0; req_wdata = '0; req_wmask = '0;
        @(negedge clock);
        n_total++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL raw_rd_ready: got %b want 1", req_ready); end
        advance();
        req_valid = 1'b0;
        n = 0;
        @(negedge clock);
        while (!resp_valid && n < 20) begin
            advance(); @(negedge clock); n++;
        end
        n_total++; if (resp_rdata !== x || resp_valid !== 1'b1) begin
            n_bad++; $display("FAIL raw_data: got %h (valid %b) want %h", resp_rdata, resp_valid, x);
        end
        advance();
    endtask

    task automatic test_reset_mid();
        logic [DATA_W-1:0] data;
        int stale;
        resp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0;
        for (int a = 0; a < 3; a++) begin
            req_addr = ADDR_W'(a);
            @(negedge clock);
            n_total++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL mid_fire[%0d]: got %b want 1", a, req_ready); end
            advance();
        end
        req_valid = 1'b0;
        test_reset();
        test_init();
        resp_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (resp_valid !== 1'b0) stale++;
            advance();
        end
        n_total++; if (stale != 0) begin n_bad++; $display("FAIL mid_stale: got %0d stale cycles want 0", stale); end
        do_read(ADDR_W'(1), data);
        n_total++; if (data !== {DATA_W{1'b0}}) begin n_bad++; $display("FAIL mid_reinit: got %h want 0", data); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        advance();
        test_reset();
        test_init();
        test_masked_write();
        test_back_to_back();
        test_backpressure();
        test_write_then_read();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
